exu_issue_scheduler: RTL and testbench

//   Issue sequencer in front of the ALU/MDU/FPU execution unit. Accepts one op per cycle

---
 rtl/exu_issue_scheduler.sv | 151 +++++++++++++++
 tb/tb_exu_issue_scheduler.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_issue_scheduler.sv
// Issue sequencer for the ALU/MDU/FPU execution unit: result-bus reservation, MDU busy
// blocking and writeback alignment. Optional flush support via EXU_SCHED_FLUSH_EN.
module exu_issue_scheduler #(
  parameter int unsigned ALU_LAT = 1,
  parameter int unsigned MDU_LAT = 4,
  parameter int unsigned FPU_LAT = 6,
  parameter int unsigned TAG_W   = 5
) (
  input  logic             iClk,
  input  logic             iRst,
`ifdef EXU_SCHED_FLUSH_EN
  input  logic             iFlush,
`endif
  input  logic             iIssueValid,
  output logic             oIssueReady,
  input  logic [1:0]       iExuOp,
  input  logic [3:0]       iAluOp,
  input  logic             iMduOp,
  input  logic [2:0]       iFpuOp,
  input  logic [TAG_W-1:0] iDstTag,
  output logic [1:0]       oExuOp,
  output logic [3:0]       oAluOp,
  output logic             oMduOp,
  output logic [2:0]       oFpuOp,
  output logic             oWbValid,
  output logic [TAG_W-1:0] oWbTag,
  output logic [1:0]       oWbUnit,
  output logic             oBusy
);

  localparam int unsigned MAX_AM = (ALU_LAT > MDU_LAT) ? ALU_LAT : MDU_LAT;
  localparam int unsigned MAXL   = (MAX_AM > FPU_LAT) ? MAX_AM : FPU_LAT;
  localparam int unsigned CNT_W  = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;

  typedef enum logic [1:0] {
    UNIT_ALU = 2'b00,
    UNIT_MDU = 2'b01,
    UNIT_FPU = 2'b10,
    UNIT_NOP = 2'b11
  } unit_e;

  // Entry i holds the result that appears on the bus i cycles from now; entry 0 is the
  // registered writeback output itself.
  logic [MAXL-1:0]  vld_q, vld_d;
  unit_e            unit_q [MAXL];
  unit_e            unit_d [MAXL];
  logic [TAG_W-1:0] tag_q  [MAXL];
  logic [TAG_W-1:0] tag_d  [MAXL];
  logic [CNT_W-1:0] mdu_cnt_q, mdu_cnt_d;

  logic             flush;
  logic [MAXL:0]    occ;
  unit_e            req_unit;
  logic             slot_free;
  logic             mdu_ok;
  logic             ready;
  logic             fire;
  logic             do_ins;
  int unsigned      ins_idx;

`ifdef EXU_SCHED_FLUSH_EN
  assign flush = iFlush;
`else
  assign flush = 1'b0;
`endif

  // Padded so the slot beyond the table (latency == MAXL) always reads as free.
  assign occ      = {1'b0, vld_q};
  assign req_unit = unit_e'(iExuOp);

  always_comb begin
    slot_free = 1'b1;
    ins_idx   = 0;
    case (req_unit)
      UNIT_ALU: begin slot_free = !occ[ALU_LAT]; ins_idx = ALU_LAT - 1; end
      UNIT_MDU: begin slot_free = !occ[MDU_LAT]; ins_idx = MDU_LAT - 1; end
      UNIT_FPU: begin slot_free = !occ[FPU_LAT]; ins_idx = FPU_LAT - 1; end
      default:  begin slot_free = 1'b1;          ins_idx = 0;           end
    endcase
  end

  assign mdu_ok = !((req_unit == UNIT_MDU) && (mdu_cnt_q != '0));
  assign ready  = !iRst && !flush && slot_free && mdu_ok;
  assign fire   = iIssueValid && ready;
  assign do_ins = fire && (req_unit != UNIT_NOP);

  always_comb begin
    vld_d     = '0;
    mdu_cnt_d = mdu_cnt_q;
    for (int unsigned i = 0; i < MAXL - 1; i++) begin
      vld_d[i]  = vld_q[i+1];
      unit_d[i] = unit_q[i+1];
      tag_d[i]  = tag_q[i+1];
    end
    unit_d[MAXL-1] = UNIT_ALU;
    tag_d[MAXL-1]  = '0;

    if (do_ins) begin
      for (int unsigned i = 0; i < MAXL; i++) begin
        if (i == ins_idx) begin
          vld_d[i]  = 1'b1;
          unit_d[i] = req_unit;
          tag_d[i]  = iDstTag;
        end
      end
    end

    if (fire && (req_unit == UNIT_MDU)) begin
      mdu_cnt_d = CNT_W'(MDU_LAT - 1);
    end else if (mdu_cnt_q != '0) begin
      mdu_cnt_d = mdu_cnt_q - 1'b1;
    end

    if (flush) begin
      vld_d     = '0;
      mdu_cnt_d = '0;
      for (int unsigned i = 0; i < MAXL; i++) begin
        unit_d[i] = UNIT_ALU;
        tag_d[i]  = '0;
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      vld_q     <= '0;
      mdu_cnt_q <= '0;
      for (int unsigned i = 0; i < MAXL; i++) begin
        unit_q[i] <= UNIT_ALU;
        tag_q[i]  <= '0;
      end
    end else begin
      vld_q     <= vld_d;
      unit_q    <= unit_d;
      tag_q     <= tag_d;
      mdu_cnt_q <= mdu_cnt_d;
    end
  end

  assign oIssueReady = ready;
  assign oExuOp      = fire ? iExuOp : 2'b11;
  assign oAluOp      = fire ? iAluOp : '0;
  assign oMduOp      = fire ? iMduOp : 1'b0;
  assign oFpuOp      = fire ? iFpuOp : '0;

  assign oWbValid = vld_q[0];
  assign oWbTag   = tag_q[0];
  assign oWbUnit  = unit_q[0];
  assign oBusy    = (|vld_q) || (mdu_cnt_q != '0);

endmodule

// File: tb/tb_exu_issue_scheduler.sv
// Directed bench for exu_issue_scheduler (default latencies 1/4/6, TAG_W=5).
module tb_exu_issue_scheduler;

  logic       iClk;
  logic       iRst;
  logic       iFlush;
  logic       iIssueValid;
  logic       oIssueReady;
  logic [1:0] iExuOp;
  logic [3:0] iAluOp;
  logic       iMduOp;
  logic [2:0] iFpuOp;
  logic [4:0] iDstTag;
  logic [1:0] oExuOp;
  logic [3:0] oAluOp;
  logic       oMduOp;
  logic [2:0] oFpuOp;
  logic       oWbValid;
  logic [4:0] oWbTag;
  logic [1:0] oWbUnit;
  logic       oBusy;

  int checks;
  int failures;

  exu_issue_scheduler #(
    .ALU_LAT(1),
    .MDU_LAT(4),
    .FPU_LAT(6),
    .TAG_W(5)
  ) dut (
    .iClk(iClk),
    .iRst(iRst),
`ifdef EXU_SCHED_FLUSH_EN
    .iFlush(iFlush),
`endif
    .iIssueValid(iIssueValid),
    .oIssueReady(oIssueReady),
    .iExuOp(iExuOp),
    .iAluOp(iAluOp),
    .iMduOp(iMduOp),
    .iFpuOp(iFpuOp),
    .iDstTag(iDstTag),
    .oExuOp(oExuOp),
    .oAluOp(oAluOp),
    .oMduOp(oMduOp),
    .oFpuOp(oFpuOp),
    .oWbValid(oWbValid),
    .oWbTag(oWbTag),
    .oWbUnit(oWbUnit),
    .oBusy(oBusy)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Stimulus word {valid, unit[1:0], tag[4:0]}
  function automatic logic [7:0] st(input int v, input int u, input int t);
    logic [31:0] vv, uu, tt;
    vv = v; uu = u; tt = t;
    return {vv[0], uu[1:0], tt[4:0]};
  endfunction

  // Expected word {ready, busy, wb_valid, wb_unit[1:0], wb_tag[4:0]}
  function automatic logic [9:0] ev(input int r, input int b, input int w, input int u, input int t);
    logic [31:0] rr, bb, ww, uu, tt;
    rr = r; bb = b; ww = w; uu = u; tt = t;
    return {rr[0], bb[0], ww[0], uu[1:0], tt[4:0]};
  endfunction

  task automatic drive(input logic [7:0] s);
    iIssueValid = s[7];
    iExuOp      = s[6:5];
    iDstTag     = s[4:0];
  endtask

  task automatic next_cycle();
    @(posedge iClk);
    #1;
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    iRst = 1'b1;
    drive(st(1, 0, 3));
    next_cycle();
    next_cycle();
    #1;
    obs = {oIssueReady, oBusy, oWbValid, oWbUnit, oWbTag};
    checks++;
    if (obs !== 10'd0) begin
      failures++;
      $display("FAIL reset_state got=%b want=%b", obs, 10'd0);
    end
    checks++;
    if (oExuOp !== 2'b11) begin
      failures++;
      $display("FAIL reset_exuop got=%b want=11", oExuOp);
    end
    iRst = 1'b0;
    drive(st(0, 3, 0));
    next_cycle();
  endtask

  task automatic test_alu_stream();
    logic [7:0] stim [5];
    logic [9:0] exp  [5];
    logic [9:0] obs;
    logic [9:0] fwd;
    stim = '{st(1,0,3), st(1,0,4), st(1,0,5), st(0,3,0), st(0,3,0)};
    exp  = '{ev(1,0,0,0,0), ev(1,1,1,0,3), ev(1,1,1,0,4), ev(1,1,1,0,5), ev(1,0,0,0,0)};
    for (int t = 0; t < 5; t++) begin
      drive(stim[t]);
      #1;
      obs = {oIssueReady, oBusy, oWbValid, oWbUnit, oWbTag};
      checks++;
      if (obs !== exp[t]) begin
        failures++;
        $display("FAIL alu_stream t=%0d got=%b want=%b", t, obs, exp[t]);
      end
      fwd = {oExuOp, oAluOp, oMduOp, oFpuOp};
      if (t == 0) begin
        checks++;
        if (fwd !== {2'b00, 4'hA, 1'b1, 3'd5}) begin
          failures++;
          $display("FAIL fwd_on_fire got=%b want=%b", fwd, {2'b00, 4'hA, 1'b1, 3'd5});
        end
      end
      if (t == 3) begin
        checks++;
        if (fwd !== {2'b11, 4'h0, 1'b0, 3'd0}) begin
          failures++;
          $display("FAIL fwd_idle got=%b want=%b", fwd, {2'b11, 4'h0, 1'b0, 3'd0});
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_bus_collision();
    logic [7:0] stim [7];
    logic [9:0] exp  [7];
    logic [9:0] obs;
    logic [9:0] fwd;
    stim = '{st(1,1,7), st(0,3,0), st(0,3,0), st(1,0,8), st(1,0,8), st(0,3,0), st(0,3,0)};
    exp  = '{ev(1,0,0,0,0), ev(1,1,0,0,0), ev(1,1,0,0,0), ev(0,1,0,0,0),
             ev(1,1,1,1,7), ev(1,1,1,0,8), ev(1,0,0,0,0)};
    for (int t = 0; t < 7; t++) begin
      drive(stim[t]);
      #1;
      obs = {oIssueReady, oBusy, oWbValid, oWbUnit, oWbTag};
      checks++;
      if (obs !== exp[t]) begin
        failures++;
        $display("FAIL bus_collision t=%0d got=%b want=%b", t, obs, exp[t]);
      end
      if (t == 3) begin
        fwd = {oExuOp, oAluOp, oMduOp, oFpuOp};
        checks++;
        if (fwd !== {2'b11, 4'h0, 1'b0, 3'd0}) begin
          failures++;
          $display("FAIL fwd_stalled got=%b want=%b", fwd, {2'b11, 4'h0, 1'b0, 3'd0});
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_mdu_busy();
    logic [7:0] stim [10];
    logic [9:0] exp  [10];
    logic [9:0] obs;
    stim = '{st(1,1,9), st(1,1,10), st(1,1,10), st(1,1,10), st(1,1,10),
             st(0,3,0), st(0,3,0), st(0,3,0), st(0,3,0), st(0,3,0)};
    exp  = '{ev(1,0,0,0,0), ev(0,1,0,0,0), ev(0,1,0,0,0), ev(0,1,0,0,0), ev(1,1,1,1,9),
             ev(1,1,0,0,0), ev(1,1,0,0,0), ev(1,1,0,0,0), ev(1,1,1,1,10), ev(1,0,0,0,0)};
    for (int t = 0; t < 10; t++) begin
      drive(stim[t]);
      #1;
      obs = {oIssueReady, oBusy, oWbValid, oWbUnit, oWbTag};
      checks++;
      if (obs !== exp[t]) begin
        failures++;
        $display("FAIL mdu_busy t=%0d got=%b want=%b", t, obs, exp[t]);
      end
      next_cycle();
    end
  endtask

  task automatic test_fpu_pipe();
    logic [7:0] stim [10];
    logic [9:0] exp  [10];
    logic [9:0] obs;
    stim = '{st(1,2,1), st(1,2,2), st(1,2,3), st(0,3,0), st(0,3,0),
             st(0,3,0), st(0,3,0), st(0,3,0), st(0,3,0), st(0,3,0)};
    exp  = '{ev(1,0,0,0,0), ev(1,1,0,0,0), ev(1,1,0,0,0), ev(1,1,0,0,0), ev(1,1,0,0,0),
             ev(1,1,0,0,0), ev(1,1,1,2,1), ev(1,1,1,2,2), ev(1,1,1,2,3), ev(1,0,0,0,0)};
    for (int t = 0; t < 10; t++) begin
      drive(stim[t]);
      #1;
      obs = {oIssueReady, oBusy, oWbValid, oWbUnit, oWbTag};
      checks++;
      if (obs !== exp[t]) begin
        failures++;
        $display("FAIL fpu_pipe t=%0d got=%b want=%b", t, obs, exp[t]);
      end
      next_cycle();
    end
  endtask

  task automatic test_mixed_units();
    logic [7:0] stim [9];
    logic [9:0] exp  [9];
    logic [9:0] obs;
    stim = '{st(1,1,1), st(1,2,2), st(1,0,3), st(0,3,0), st(0,3,0),
             st(0,3,0), st(0,3,0), st(0,3,0), st(0,3,0)};
    exp  = '{ev(1,0,0,0,0), ev(1,1,0,0,0), ev(1,1,0,0,0), ev(1,1,1,0,3), ev(1,1,1,1,1),
             ev(1,1,0,0,0), ev(1,1,0,0,0), ev(1,1,1,2,2), ev(1,0,0,0,0)};
    for (int t = 0; t < 9; t++) begin
      drive(stim[t]);
      #1;
      obs = {oIssueReady, oBusy, oWbValid, oWbUnit, oWbTag};
      checks++;
      if (obs !== exp[t]) begin
        failures++;
        $display("FAIL mixed_units t=%0d got=%b want=%b", t, obs, exp[t]);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_midop();
    logic [8:0] obs;
    drive(st(1, 2, 6));
    next_cycle();
    drive(st(0, 3, 0));
    next_cycle();
    iRst = 1'b1;
    drive(st(1, 0, 9));
    #1;
    checks++;
    if ({oIssueReady, oExuOp} !== 3'b011) begin
      failures++;
      $display("FAIL reset_midop_ready got=%b want=011", {oIssueReady, oExuOp});
    end
    next_cycle();
    iRst = 1'b0;
    drive(st(0, 3, 0));
    for (int t = 3; t < 9; t++) begin
      #1;
      obs = {oBusy, oWbValid, oWbUnit, oWbTag};
      checks++;
      if (obs !== 9'd0) begin
        failures++;
        $display("FAIL reset_midop t=%0d got=%b want=%b", t, obs, 9'd0);
      end
      next_cycle();
    end
  endtask

`ifdef EXU_SCHED_FLUSH_EN
  task automatic test_flush();
    logic [7:0] stim [9];
    logic [9:0] exp  [9];
    logic       fl   [9];
    logic [9:0] obs;
    stim = '{st(1,1,1), st(1,2,2), st(1,0,4), st(1,1,3), st(0,3,0),
             st(0,3,0), st(0,3,0), st(0,3,0), st(0,3,0)};
    fl   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    exp  = '{ev(1,0,0,0,0), ev(1,1,0,0,0), ev(0,1,0,0,0), ev(1,0,0,0,0), ev(1,1,0,0,0),
             ev(1,1,0,0,0), ev(1,1,0,0,0), ev(1,1,1,1,3), ev(1,0,0,0,0)};
    for (int t = 0; t < 9; t++) begin
      drive(stim[t]);
      iFlush = fl[t];
      #1;
      obs = {oIssueReady, oBusy, oWbValid, oWbUnit, oWbTag};
      checks++;
      if (obs !== exp[t]) begin
        failures++;
        $display("FAIL flush t=%0d got=%b want=%b", t, obs, exp[t]);
      end
      next_cycle();
    end
    iFlush = 1'b0;
  endtask
`endif

  task automatic test_nop();
    logic [9:0] obs;
    for (int t = 0; t < 6; t++) begin
      if (t < 4) drive(st(1, 3, 12));
      else       drive(st(0, 3, 0));
      #1;
      obs = {oIssueReady, oBusy, oWbValid, oWbUnit, oWbTag};
      checks++;
      if (obs !== ev(1,0,0,0,0)) begin
        failures++;
        $display("FAIL nop t=%0d got=%b want=%b", t, obs, ev(1,0,0,0,0));
      end
      next_cycle();
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    iRst        = 1'b1;
    iFlush      = 1'b0;
    iIssueValid = 1'b0;
    iExuOp      = 2'b11;
    iAluOp      = 4'hA;
    iMduOp      = 1'b1;
    iFpuOp      = 3'd5;
    iDstTag     = '0;

    test_reset();
    test_alu_stream();
    test_bus_collision();
    test_mdu_busy();
    test_fpu_pipe();
    test_mixed_units();
    test_reset_midop();
`ifdef EXU_SCHED_FLUSH_EN
    test_flush();
`endif
    test_nop();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
